regfile_multiport: RTL and testbench

- Parametrised general-purpose register file for the single-cycle RISC-V core.
- Successor to the fixed 32x32, 2-read-port register file, with configurable width, depth and read-port count.
- Adds a sequenced hardware clear after reset, hardwired-zero x0 and a ready/busy indication.
- Sits between decode (read addresses) and writeback (write port).

---
 rtl/regfile_multiport.sv | 119 +++++++++++
 tb/tb_regfile_multiport.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// regfile_multiport: parametrised multi-read-port GPR file for the single-cycle
// RISC-V core. After every reset a hardware sequencer sweeps all registers to
// zero (busy high, clr_done pulses on the last sweep cycle). Register 0 can be
// hardwired to zero via ZERO_REG.
//
// Optional build macro: REGFILE_BYPASS_EN
//   defined   -> same-cycle write-through forwarding from the write port to
//                any read port addressing the register being written.
//   undefined -> reads in the write cycle return the previously stored value.
module regfile_multiport #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  output logic                busy,
  output logic                clr_done
);

  localparam int NREGS = 2 ** AW;

  typedef enum logic {
    IDLE_CLR,
    READY
  } state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   clr_ptr, clr_ptr_nxt;
  logic            clr_we;
  logic            user_wr;
  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] mem [NREGS];

  // A write to register 0 is discarded when it is hardwired to zero.
  assign user_wr = (state == READY) && !rst && we &&
                   !((ZERO_REG != 0) && (wa == '0));

  // Reads are blanked for the whole clear sweep, including the reset cycles.
  assign busy = rst || (state == IDLE_CLR);

  // State register and clear pointer, with synchronous reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE_CLR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  // Next-state logic: one register cleared per cycle, leave at the last one.
  // NOTE: every output of this block is given a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    clr_we      = 1'b0;
    clr_done    = 1'b0;
    if (!rst) begin
      case (state)
        IDLE_CLR: begin
          clr_we = 1'b1;
          if (clr_ptr == AW'(NREGS - 1)) begin
            clr_done  = 1'b1;
            state_nxt = READY;
          end else begin
            clr_ptr_nxt = clr_ptr + AW'(1);
          end
        end
        READY: begin
          state_nxt = READY;
        end
        default: begin
          state_nxt = IDLE_CLR;
        end
      endcase
    end
  end

  // Single write port shared by the clear sequencer and the external writer.
  // NOTE: the storage array has no reset branch on purpose; clearing it is the
  // sequencer's job, which keeps the array mappable onto plain RAM/flops
  // without a reset network.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_ptr] <= '0;
    end else if (user_wr) begin
      mem[wa] <= wd;
    end
  end

  // Combinational read ports, blanked while busy and for hardwired x0.
  always_comb begin
    rd      = '0;
    rd_addr = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_addr = ra[i*AW +: AW];
      if (!busy && !((ZERO_REG != 0) && (rd_addr == '0))) begin
        rd[i*XLEN +: XLEN] = mem[rd_addr];
`ifdef REGFILE_BYPASS_EN
        if (user_wr && (wa == rd_addr)) begin
          rd[i*XLEN +: XLEN] = wd;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench for regfile_multiport. Two instances (ZERO_REG=1 and
// ZERO_REG=0) share stimulus. A behavioural model (a countdown of remaining
// clear cycles plus a plain array per instance) predicts every output on every
// cycle; directed sequences add literal expectations for the documented cases.
module tb_regfile_multiport;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int NREGS = 2 ** AW;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   ra;
  logic                we;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
  logic [NRD*XLEN-1:0] rd1, rd0;
  logic                busy1, busy0, clr_done1, clr_done0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_multiport #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd1), .we(we), .wa(wa), .wd(wd),
    .busy(busy1), .clr_done(clr_done1)
  );

  regfile_multiport #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd0), .we(we), .wa(wa), .wd(wd),
    .busy(busy0), .clr_done(clr_done0)
  );

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [XLEN-1:0] m1 [NREGS];
  logic [XLEN-1:0] m0 [NREGS];
  int clr_left = NREGS;
  bit model_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      clr_left = NREGS;
      model_en = 1'b1;
    end else if (clr_left > 0) begin
      m1[NREGS - clr_left] = '0;
      m0[NREGS - clr_left] = '0;
      clr_left--;
    end else if (we) begin
      if (wa != 0) m1[wa] = wd;
      m0[wa] = wd;
    end
  end

  function automatic logic [XLEN-1:0] exp_rd(input bit zr, input int port);
    int a;
    a = int'(ra[port*AW +: AW]);
    if (rst || clr_left > 0) return '0;
    if (zr && a == 0) return '0;
    if (BYP && we && int'(wa) == a) return wd;
    return zr ? m1[a] : m0[a];
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_en) begin
      for (int i = 0; i < NRD; i++) begin
        check($sformatf("model rd z1 port%0d", i), rd1[i*XLEN +: XLEN], exp_rd(1'b1, i));
        check($sformatf("model rd z0 port%0d", i), rd0[i*XLEN +: XLEN], exp_rd(1'b0, i));
      end
      check("model busy z1", XLEN'(busy1), XLEN'(rst || clr_left > 0));
      check("model busy z0", XLEN'(busy0), XLEN'(rst || clr_left > 0));
      check("model clr_done z1", XLEN'(clr_done1), XLEN'(!rst && clr_left == 1));
      check("model clr_done z0", XLEN'(clr_done0), XLEN'(!rst && clr_left == 1));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge that sampled rst=1. Releases reset and walks the
  // clear window. abort_at>0 re-asserts rst in that cycle and returns there.
  task automatic sweep(input int abort_at, input int wr_cycle);
    int pulses = 0;
    rst = 1'b0;
    for (int c = 1; c <= NREGS + 1; c++) begin
      if (c > 1) step();
      we = 1'b0;
      ra = {AW'($urandom_range(0, NREGS - 1)), AW'(31)};
      if (c == wr_cycle) begin
        we = 1'b1; wa = AW'(31); wd = 32'h12345678;
      end
      if (c == abort_at) rst = 1'b1;
      @(negedge clk);
      if (clr_done1) pulses++;
      check($sformatf("sweep busy c%0d", c), XLEN'(busy1), XLEN'(c <= NREGS));
      check($sformatf("sweep clr_done c%0d", c), XLEN'(clr_done1),
            XLEN'(c == NREGS && abort_at == 0));
      if (c <= NREGS) check($sformatf("sweep rd blank c%0d", c), rd1[XLEN-1:0], '0);
      if (c == abort_at) return;
    end
    check("clr_done pulse count", XLEN'(pulses), XLEN'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = '0;
    repeat (2) step();
    sweep(0, 10);

    // Every register reads zero after the sweep, including r31 written mid-clear.
    for (int a = 0; a < NREGS; a++) begin
      step();
      ra = {AW'(NREGS - 1 - a), AW'(a)};
      @(negedge clk);
      check("post-clear rd0", rd1[XLEN-1:0], '0);
      check("post-clear rd1", rd1[2*XLEN-1:XLEN], '0);
      check("post-clear z0 rd0", rd0[XLEN-1:0], '0);
    end

    // Basic write then read on two ports.
    step(); we = 1'b1; wa = AW'(5); wd = 32'h5; @(negedge clk);
    step(); we = 1'b1; wa = AW'(6); wd = 32'h4; @(negedge clk);
    step(); we = 1'b0; ra = {AW'(6), AW'(5)}; @(negedge clk);
    check("basic port1 r6", rd1[2*XLEN-1:XLEN], 32'h4);
    check("basic port0 r5", rd1[XLEN-1:0], 32'h5);

    // x0 behaviour for both ZERO_REG settings.
    step(); we = 1'b1; wa = '0; wd = 32'hDEADBEEF; @(negedge clk);
    step(); we = 1'b0; ra = '0; @(negedge clk);
    check("x0 hardwired", rd1[XLEN-1:0], 32'h0);
    check("x0 ordinary", rd0[XLEN-1:0], 32'hDEADBEEF);
    check("x0 ordinary port1", rd0[2*XLEN-1:XLEN], 32'hDEADBEEF);

    // Same-cycle read/write on x7.
    step(); we = 1'b1; wa = AW'(7); wd = 32'h11; @(negedge clk);
    step(); we = 1'b1; wa = AW'(7); wd = 32'h22; ra = {AW'(7), AW'(7)}; @(negedge clk);
    check("x7 same-cycle port0", rd1[XLEN-1:0], BYP ? 32'h22 : 32'h11);
    check("x7 same-cycle port1", rd1[2*XLEN-1:XLEN], BYP ? 32'h22 : 32'h11);
    step(); we = 1'b0; @(negedge clk);
    check("x7 next cycle", rd1[XLEN-1:0], 32'h22);

    // Reset in READY, then reset again at clear cycle 15.
    step(); rst = 1'b1; @(negedge clk);
    check("busy under rst", XLEN'(busy1), XLEN'(1));
    step();
    sweep(15, 0);
    step();
    sweep(0, 0);

    // Randomised traffic, including occasional resets.
    for (int n = 0; n < 600; n++) begin
      step();
      rst = ($urandom_range(0, 249) == 0);
      we  = 1'($urandom_range(0, 1));
      wa  = AW'($urandom_range(0, 3) == 0 ? $urandom_range(0, NREGS - 1)
                                          : $urandom_range(0, 7));
      wd  = $urandom();
      ra[AW-1:0]    = AW'($urandom_range(0, 7));
      ra[2*AW-1:AW] = ($urandom_range(0, 3) == 0) ? ra[AW-1:0]
                                                  : AW'($urandom_range(0, NREGS - 1));
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
